// File: rtl/id_register_file_if.sv
// Decode-stage register file bus: read ports, write-back port, status update and condition check.
interface id_register_file_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] pc_in;
    logic [3:0]        src1;
    logic [3:0]        src2;
    logic [DATA_W-1:0] val1;
    logic [DATA_W-1:0] val2;
    logic              wb_en;
    logic [3:0]        wb_dest;
    logic [DATA_W-1:0] wb_value;
    logic              sr_update;
    logic [3:0]        status_in;
    logic              freeze;
    logic [3:0]        cond;
    logic [3:0]        status_out;
    logic              cond_pass;

    // No valid/ready handshake here: reads are combinational every cycle and
    // wb_en / sr_update are single-cycle strobes sampled on the rising clock edge.
    modport master (
        output pc_in, src1, src2, wb_en, wb_dest, wb_value,
               sr_update, status_in, freeze, cond,
        input  val1, val2, status_out, cond_pass
    );

    modport slave (
        input  pc_in, src1, src2, wb_en, wb_dest, wb_value,
               sr_update, status_in, freeze, cond,
        output val1, val2, status_out, cond_pass
    );
endinterface

// File: rtl/id_register_file.sv
// Decode-stage architectural state: R0..R14, NZCV, two bypassed read ports with
// R15 returning the pipelined PC, and instruction condition evaluation.
module id_register_file #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 15
) (
    input logic              clk,
    input logic              rst,
    id_register_file_if.slave rf
);

    localparam logic [3:0] PC_IDX = 4'd15;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [3:0]        nzcv;
    logic              flag_n, flag_z, flag_c, flag_v;

    // Index 15 is the PC alias and never a storage location, so those writes are dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (rf.wb_en && (rf.wb_dest != PC_IDX) && (32'(rf.wb_dest) < NUM_REGS)) begin
            regs[rf.wb_dest] <= rf.wb_value;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            nzcv <= 4'b0000;
        end else if (rf.sr_update && !rf.freeze) begin
            nzcv <= rf.status_in;
        end
    end

    // Same-cycle write-back bypass avoids a stale read while WB commits at the edge.
    always_comb begin
        rf.val1 = '0;
        if (rf.src1 == PC_IDX) begin
            rf.val1 = rf.pc_in;
        end else if (rf.wb_en && (rf.wb_dest == rf.src1)) begin
            rf.val1 = rf.wb_value;
        end else if (32'(rf.src1) < NUM_REGS) begin
            rf.val1 = regs[rf.src1];
        end
    end

    always_comb begin
        rf.val2 = '0;
        if (rf.src2 == PC_IDX) begin
            rf.val2 = rf.pc_in;
        end else if (rf.wb_en && (rf.wb_dest == rf.src2)) begin
            rf.val2 = rf.wb_value;
        end else if (32'(rf.src2) < NUM_REGS) begin
            rf.val2 = regs[rf.src2];
        end
    end

    assign {flag_n, flag_z, flag_c, flag_v} = nzcv;
    assign rf.status_out = nzcv;

    // Condition uses only the registered flags; code 4'hF is treated as always.
    always_comb begin
        rf.cond_pass = 1'b1;
        case (rf.cond)
            4'h0: rf.cond_pass = flag_z;
            4'h1: rf.cond_pass = !flag_z;
            4'h2: rf.cond_pass = flag_c;
            4'h3: rf.cond_pass = !flag_c;
            4'h4: rf.cond_pass = flag_n;
            4'h5: rf.cond_pass = !flag_n;
            4'h6: rf.cond_pass = flag_v;
            4'h7: rf.cond_pass = !flag_v;
            4'h8: rf.cond_pass = flag_c && !flag_z;
            4'h9: rf.cond_pass = !flag_c || flag_z;
            4'hA: rf.cond_pass = (flag_n == flag_v);
            4'hB: rf.cond_pass = (flag_n != flag_v);
            4'hC: rf.cond_pass = !flag_z && (flag_n == flag_v);
            4'hD: rf.cond_pass = flag_z || (flag_n != flag_v);
            default: rf.cond_pass = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_id_register_file.sv
// Directed self-checking bench for id_register_file: reset, write/read, bypass,
// R15 alias, status freeze and full condition-code sweeps.
module tb_id_register_file;

    logic clk;
    logic rst_n;

    id_register_file_if #(.DATA_W(32)) rf_if ();

    id_register_file #(.DATA_W(32), .NUM_REGS(15)) dut (
        .clk (clk),
        .rst (rst_n),
        .rf  (rf_if)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q [$];
    logic [31:0] model [15];

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, need completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // driver tasks
    task automatic drive_idle();
        rf_if.pc_in     = 32'h0;
        rf_if.src1      = 4'd0;
        rf_if.src2      = 4'd0;
        rf_if.wb_en     = 1'b0;
        rf_if.wb_dest   = 4'd0;
        rf_if.wb_value  = 32'h0;
        rf_if.sr_update = 1'b0;
        rf_if.status_in = 4'b0000;
        rf_if.freeze    = 1'b0;
        rf_if.cond      = 4'hE;
    endtask

    task automatic do_write(input logic [3:0] dest, input logic [31:0] value);
        @(negedge clk);
        rf_if.wb_en    = 1'b1;
        rf_if.wb_dest  = dest;
        rf_if.wb_value = value;
        @(posedge clk);
        #1;
        rf_if.wb_en = 1'b0;
        if (dest != 4'd15) model[dest] = value;
    endtask

    task automatic set_flags(input logic [3:0] flags, input logic frz);
        @(negedge clk);
        rf_if.sr_update = 1'b1;
        rf_if.status_in = flags;
        rf_if.freeze    = frz;
        @(posedge clk);
        #1;
        rf_if.sr_update = 1'b0;
        rf_if.freeze    = 1'b0;
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < 15; i++) begin
            rf_if.src1 = 4'(i);
            #1;
            check($sformatf("%s_r%0d", tag, i), rf_if.val1, model[i]);
        end
    endtask

    // golden rows indexed by cond code, hand-derived from the condition table
    logic golden_1001 [16] = '{0,1,0,1, 1,0,1,0, 0,1,1,0, 1,0,1,1};
    logic golden_0110 [16] = '{1,0,1,0, 0,1,0,1, 0,1,1,0, 0,1,1,1};
    logic golden_0010 [16] = '{0,1,1,0, 0,1,0,1, 1,0,1,0, 1,0,1,1};

    task automatic cond_sweep(input string tag, input logic [3:0] flags);
        for (int c = 0; c < 16; c++) begin
            case (flags)
                4'b1001: exp_q.push_back({31'b0, golden_1001[c]});
                4'b0110: exp_q.push_back({31'b0, golden_0110[c]});
                default: exp_q.push_back({31'b0, golden_0010[c]});
            endcase
        end
        for (int c = 0; c < 16; c++) begin
            logic [31:0] e;
            rf_if.cond = 4'(c);
            #1;
            e = exp_q.pop_front();
            check($sformatf("%s_cond%0h", tag, c), {31'b0, rf_if.cond_pass}, e);
        end
    endtask

    initial begin
        for (int i = 0; i < 15; i++) model[i] = 32'h0;
        drive_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // reset state
        rf_if.src1 = 4'd0;
        rf_if.src2 = 4'd14;
        rf_if.cond = 4'h0;
        #1;
        check("rst_val1", rf_if.val1, 32'h0);
        check("rst_val2", rf_if.val2, 32'h0);
        check("rst_status", {28'b0, rf_if.status_out}, 32'h0);
        check("rst_eq", {31'b0, rf_if.cond_pass}, 32'h0);

        // write then read next cycle
        do_write(4'd3, 32'hDEADBEEF);
        rf_if.src1 = 4'd3;
        #1;
        check("wr_r3", rf_if.val1, 32'hDEADBEEF);

        // bypass on both ports before the edge
        @(negedge clk);
        rf_if.wb_en = 1'b1; rf_if.wb_dest = 4'd5; rf_if.wb_value = 32'd7;
        rf_if.src1 = 4'd5; rf_if.src2 = 4'd5;
        #1;
        check("byp_val1", rf_if.val1, 32'd7);
        check("byp_val2", rf_if.val2, 32'd7);
        @(posedge clk); #1;
        rf_if.wb_en = 1'b0;
        model[5] = 32'd7;
        #1;
        check("byp_commit", rf_if.val2, 32'd7);

        // bypass overrides an older stored value
        @(negedge clk);
        rf_if.wb_en = 1'b1; rf_if.wb_dest = 4'd3; rf_if.wb_value = 32'h0000_1234;
        rf_if.src1 = 4'd3; rf_if.src2 = 4'd4;
        #1;
        check("byp_new_r3", rf_if.val1, 32'h0000_1234);
        check("byp_other_port", rf_if.val2, 32'h0);
        @(posedge clk); #1;
        rf_if.wb_en = 1'b0;
        model[3] = 32'h0000_1234;

        // R15 alias wins over a bypass to index 15, and that write is dropped
        @(negedge clk);
        rf_if.pc_in = 32'h0000_0104;
        rf_if.src2 = 4'd15;
        #1;
        check("r15_pc", rf_if.val2, 32'h0000_0104);
        rf_if.wb_en = 1'b1; rf_if.wb_dest = 4'd15; rf_if.wb_value = 32'hFFFF_FFFF;
        #1;
        check("r15_no_byp", rf_if.val2, 32'h0000_0104);
        @(posedge clk); #1;
        rf_if.wb_en = 1'b0;
        do_write(4'd14, 32'hA5A5_0F0F);
        do_write(4'd0, 32'h1111_2222);
        read_all("r15_drop");

        // status update blocked by freeze, then accepted
        rf_if.cond = 4'h0;
        set_flags(4'b0100, 1'b1);
        check("frz_hold", {28'b0, rf_if.status_out}, 32'h0);
        set_flags(4'b0100, 1'b0);
        check("sr_load", {28'b0, rf_if.status_out}, 32'h4);
        rf_if.cond = 4'h0; #1;
        check("sr_eq", {31'b0, rf_if.cond_pass}, 32'h1);
        rf_if.cond = 4'h1; #1;
        check("sr_ne", {31'b0, rf_if.cond_pass}, 32'h0);

        // status_out is the registered value, not status_in
        @(negedge clk);
        rf_if.sr_update = 1'b1; rf_if.status_in = 4'b1001;
        #1;
        check("sr_no_byp", {28'b0, rf_if.status_out}, 32'h4);
        @(posedge clk); #1;
        rf_if.sr_update = 1'b0;
        check("sr_1001", {28'b0, rf_if.status_out}, 32'h9);
        cond_sweep("nzcv1001", 4'b1001);

        set_flags(4'b0110, 1'b0);
        cond_sweep("nzcv0110", 4'b0110);
        set_flags(4'b0010, 1'b0);
        cond_sweep("nzcv0010", 4'b0010);

        // mid-cycle reset clears state immediately
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        rf_if.src1 = 4'd3; rf_if.src2 = 4'd14;
        #1;
        check("mrst_val1", rf_if.val1, 32'h0);
        check("mrst_val2", rf_if.val2, 32'h0);
        check("mrst_status", {28'b0, rf_if.status_out}, 32'h0);
        for (int i = 0; i < 15; i++) model[i] = 32'h0;

        // a write and status update held during reset are lost
        rf_if.wb_en = 1'b1; rf_if.wb_dest = 4'd4; rf_if.wb_value = 32'h0000_00AA;
        rf_if.sr_update = 1'b1; rf_if.status_in = 4'b1111;
        @(posedge clk);
        @(negedge clk);
        rf_if.wb_en = 1'b0; rf_if.sr_update = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        rf_if.src2 = 4'd4;
        #1;
        check("rst_wr_lost", rf_if.val2, 32'h0);
        check("rst_sr_lost", {28'b0, rf_if.status_out}, 32'h0);
        read_all("post_rst");

        // final report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
